// File: rtl/cpu_run_controller.sv
// rtl/cpu_run_controller.sv - run/observe harness for the cpu core
//
// Purpose:
//   Holds the cpu in reset until started, counts run cycles, drives NUM_IRQ
//   programmable interrupt pulses, and ends the run on cpu completion or on
//   the MAX_CLOCKS cycle limit. It then snapshots the register file and
//   streams it out one register per beat over a valid/ready port.
//
// Optional feature:
//   RUN_CTRL_PERIODIC_IRQ_EN - adds irq_period_i; a channel with a nonzero
//   period re-fires every period cycles after its first trigger.
//
// Ports:
//   clk, rstn       clock and synchronous active-low reset
//   start           one-cycle run request (honoured in IDLE/DONE)
//   irq_en_i        per-channel interrupt enable
//   irq_at_i        per-channel trigger count, channel k at [k*CNT_W +: CNT_W]
//   irq_period_i    per-channel re-fire period (optional feature only)
//   completed_i     cpu completion flag
//   regs_i          cpu register file, reg i at [i*XLEN +: XLEN]
//   cpu_rstn_o      active-low reset to the cpu
//   irq_o           interrupt pulses to the cpu
//   busy_o          high while running or dumping
//   cycles_o        run cycles elapsed in the last run
//   timeout_o       last run ended on the cycle limit
//   dump_valid_o    dump beat valid
//   dump_idx_o      register index of the current beat
//   dump_data_o     register value of the current beat
//   dump_ready_i    sink accepts the beat
//   done_o          dump finished, results held

module cpu_run_controller #(
  parameter int NUM_IRQ    = 2,
  parameter int CNT_W      = 32,
  parameter int MAX_CLOCKS = 100000,
  parameter int IRQ_LEN    = 1,
  parameter int NREGS      = 32,
  parameter int XLEN       = 32,
  localparam int IDX_W     = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     start,
  input  logic [NUM_IRQ-1:0]       irq_en_i,
  input  logic [NUM_IRQ*CNT_W-1:0] irq_at_i,
`ifdef RUN_CTRL_PERIODIC_IRQ_EN
  input  logic [NUM_IRQ*CNT_W-1:0] irq_period_i,
`endif
  input  logic                     completed_i,
  input  logic [NREGS*XLEN-1:0]    regs_i,
  output logic                     cpu_rstn_o,
  output logic [NUM_IRQ-1:0]       irq_o,
  output logic                     busy_o,
  output logic [CNT_W-1:0]         cycles_o,
  output logic                     timeout_o,
  output logic                     dump_valid_o,
  output logic [IDX_W-1:0]         dump_idx_o,
  output logic [XLEN-1:0]          dump_data_o,
  input  logic                     dump_ready_i,
  output logic                     done_o
);

  localparam int REM_W = $clog2(IRQ_LEN + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DUMP,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0]      cnt_q;
  logic [CNT_W-1:0]      cycles_q;
  logic                  cpu_rstn_q;
  logic                  timeout_q;
  logic                  done_q;
  logic [IDX_W-1:0]      idx_q;
  logic [NREGS*XLEN-1:0] snap_q;

  logic last_cnt;
  logic run_end;
  logic beat_xfer;
  logic last_beat;

  assign last_cnt  = (cnt_q == CNT_W'(MAX_CLOCKS - 1));
  assign run_end   = (state_q == S_RUN) && (completed_i || last_cnt);
  assign beat_xfer = (state_q == S_DUMP) && dump_ready_i;
  assign last_beat = (idx_q == IDX_W'(NREGS - 1));

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_RUN;
      S_RUN:          if (run_end) state_d = S_DUMP;
      S_DUMP:         if (beat_xfer && last_beat) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  // ----------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q      <= '0;
      cycles_q   <= '0;
      cpu_rstn_q <= 1'b0;
      timeout_q  <= 1'b0;
      done_q     <= 1'b0;
      idx_q      <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            cnt_q      <= '0;
            cycles_q   <= '0;
            cpu_rstn_q <= 1'b1;
            timeout_q  <= 1'b0;
            done_q     <= 1'b0;
          end
        end
        S_RUN: begin
          // Completion takes priority over the cycle limit.
          if (completed_i) begin
            cycles_q   <= cnt_q + 1'b1;
            timeout_q  <= 1'b0;
            cpu_rstn_q <= 1'b0;
          end else if (last_cnt) begin
            cycles_q   <= CNT_W'(MAX_CLOCKS);
            timeout_q  <= 1'b1;
            cpu_rstn_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DUMP: begin
          if (beat_xfer) begin
            if (last_beat) begin
              idx_q  <= '0;
              done_q <= 1'b1;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Snapshot contents are don't-care after reset, so no reset term.
  always_ff @(posedge clk) begin
    if (run_end) begin
      snap_q <= regs_i;
    end
  end

  // ---------------------------------------------------------- interrupts
  genvar k;
  generate
    for (k = 0; k < NUM_IRQ; k++) begin : g_irq
      logic [REM_W-1:0] rem_q;
      logic             at_hit;
      logic             fire;

      assign at_hit = (cnt_q == irq_at_i[k*CNT_W +: CNT_W]);

`ifdef RUN_CTRL_PERIODIC_IRQ_EN
      // Down-counter armed at the first trigger; reaching zero marks each
      // further multiple of the period past irq_at.
      logic [CNT_W-1:0] period;
      logic [CNT_W-1:0] per_q;
      logic             armed_q;
      logic             per_hit;

      assign period  = irq_period_i[k*CNT_W +: CNT_W];
      assign per_hit = armed_q && (period != '0) && (per_q == '0);

      always_ff @(posedge clk) begin
        if (!rstn || state_q != S_RUN) begin
          armed_q <= 1'b0;
          per_q   <= '0;
        end else if (at_hit) begin
          armed_q <= 1'b1;
          per_q   <= period - 1'b1;
        end else if (armed_q) begin
          per_q <= (per_q == '0) ? period - 1'b1 : per_q - 1'b1;
        end
      end

      assign fire = (state_q == S_RUN) && irq_en_i[k] && (at_hit || per_hit);
`else
      assign fire = (state_q == S_RUN) && irq_en_i[k] && at_hit;
`endif

      // rem_q counts the pulse cycles still to come; a re-fire reloads it.
      // Leaving RUN clears it, truncating any pulse in flight.
      always_ff @(posedge clk) begin
        if (!rstn || run_end || state_q != S_RUN) begin
          rem_q <= '0;
        end else if (fire) begin
          rem_q <= REM_W'(IRQ_LEN);
        end else if (rem_q != '0) begin
          rem_q <= rem_q - 1'b1;
        end
      end

      assign irq_o[k] = (rem_q != '0);
    end
  endgenerate

  // ------------------------------------------------------------- outputs
  assign cpu_rstn_o   = cpu_rstn_q;
  assign busy_o       = (state_q == S_RUN) || (state_q == S_DUMP);
  assign cycles_o     = cycles_q;
  assign timeout_o    = timeout_q;
  assign done_o       = done_q;
  assign dump_valid_o = (state_q == S_DUMP);
  assign dump_idx_o   = idx_q;
  // Gated so the undefined snapshot never shows outside DUMP.
  assign dump_data_o  = dump_valid_o ? snap_q[int'(idx_q)*XLEN +: XLEN] : '0;

endmodule

// File: tb/tb_cpu_run_controller.sv
// tb/tb_cpu_run_controller.sv - directed vector bench for cpu_run_controller

module tb_cpu_run_controller;

  localparam int NUM_IRQ = 2;
  localparam int CNT_W   = 32;
  localparam int MAXC    = 2500;
  localparam int NREGS   = 32;
  localparam int XLEN    = 32;
  localparam int IDX_W   = 5;
`ifdef RUN_CTRL_PERIODIC_IRQ_EN
  localparam int IRQ_L   = 2;
`else
  localparam int IRQ_L   = 1;
`endif

  logic                     clk = 1'b0;
  logic                     rstn;
  logic                     start;
  logic [NUM_IRQ-1:0]       irq_en_i;
  logic [NUM_IRQ*CNT_W-1:0] irq_at_i;
  logic [NUM_IRQ*CNT_W-1:0] irq_period_i;
  logic                     completed_i;
  logic [NREGS*XLEN-1:0]    regs_i;
  logic                     cpu_rstn_o;
  logic [NUM_IRQ-1:0]       irq_o;
  logic                     busy_o;
  logic [CNT_W-1:0]         cycles_o;
  logic                     timeout_o;
  logic                     dump_valid_o;
  logic [IDX_W-1:0]         dump_idx_o;
  logic [XLEN-1:0]          dump_data_o;
  logic                     dump_ready_i;
  logic                     done_o;

  always #5 clk = ~clk;

  cpu_run_controller #(
    .NUM_IRQ   (NUM_IRQ),
    .CNT_W     (CNT_W),
    .MAX_CLOCKS(MAXC),
    .IRQ_LEN   (IRQ_L),
    .NREGS     (NREGS),
    .XLEN      (XLEN)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
    .irq_en_i    (irq_en_i),
    .irq_at_i    (irq_at_i),
`ifdef RUN_CTRL_PERIODIC_IRQ_EN
    .irq_period_i(irq_period_i),
`endif
    .completed_i (completed_i),
    .regs_i      (regs_i),
    .cpu_rstn_o  (cpu_rstn_o),
    .irq_o       (irq_o),
    .busy_o      (busy_o),
    .cycles_o    (cycles_o),
    .timeout_o   (timeout_o),
    .dump_valid_o(dump_valid_o),
    .dump_idx_o  (dump_idx_o),
    .dump_data_o (dump_data_o),
    .dump_ready_i(dump_ready_i),
    .done_o      (done_o)
  );

  typedef struct {
    int         comp;      // cnt at which completed_i is raised, -1 = never
    int         at0;
    int         at1;
    logic [1:0] en;
    logic [3:0] rdy;       // dump_ready_i pattern, bit 0 first
    int         per0;
    bit         chk_irq;
    int         exp_cycles;
    logic       exp_to;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;
  int hits0[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] regval(input int salt, input int c, input int i);
    logic [31:0] s, cc, ii;
    s  = salt;
    cc = c;
    ii = i;
    return 32'h5A5A0000 ^ (s << 24) ^ (ii << 16) ^ (cc * 32'h9E37);
  endfunction

  task automatic set_regs(input int salt, input int c);
    for (int i = 0; i < NREGS; i++) regs_i[i*XLEN +: XLEN] = regval(salt, c, i);
  endtask

  function automatic int exp_irq_cnt(input int at, input logic en, input int cend);
    int hi;
    if (!en || at >= cend) return 0;
    hi = (at + IRQ_L < cend) ? at + IRQ_L : cend;
    return hi - at;
  endfunction

  task automatic run_vec(input int vi, input vec_t v);
    int c, cend, exp_i, bad_beats;
    int cnt_k[2];
    int first_k[2];
    int at_k[2];
    bit ended;
    cnt_k   = '{0, 0};
    first_k = '{-1, -1};
    at_k    = '{v.at0, v.at1};
    hits0.delete();
    irq_en_i     = v.en;
    irq_at_i     = {CNT_W'(v.at1), CNT_W'(v.at0)};
    irq_period_i = {CNT_W'(0), CNT_W'(v.per0)};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check($sformatf("v%0d run_cpu_rstn", vi), cpu_rstn_o, 1);
    check($sformatf("v%0d run_busy", vi), busy_o, 1);
    c = 0;
    ended = 0;
    while (!ended) begin
      for (int k = 0; k < 2; k++) begin
        if (irq_o[k]) begin
          cnt_k[k]++;
          if (first_k[k] < 0) first_k[k] = c;
          if (k == 0) hits0.push_back(c);
        end
      end
      completed_i = (c == v.comp);
      start = (c == 2);            // must be ignored while running
      set_regs(vi, c);
      ended = (c == v.comp) || (c == MAXC - 1);
      @(negedge clk);
      if (!ended) c++;
    end
    cend = c;
    completed_i = 1'b0;
    start = 1'b1;                  // must be ignored while dumping
    check($sformatf("v%0d cycles", vi), cycles_o, v.exp_cycles);
    check($sformatf("v%0d timeout", vi), timeout_o, v.exp_to);
    check($sformatf("v%0d cpu_rstn_after", vi), cpu_rstn_o, 0);
    check($sformatf("v%0d irq_after", vi), irq_o, 0);
    if (v.chk_irq) begin
      for (int k = 0; k < 2; k++) begin
        int e;
        e = exp_irq_cnt(at_k[k], v.en[k], cend);
        check($sformatf("v%0d irq%0d_cycles", vi, k), cnt_k[k], e);
        if (e > 0) check($sformatf("v%0d irq%0d_first", vi, k), first_k[k], at_k[k] + 1);
      end
    end
    exp_i = 0;
    bad_beats = 0;
    for (int cyc = 0; cyc < NREGS * 8 && exp_i < NREGS; cyc++) begin
      if (!dump_valid_o || dump_idx_o != IDX_W'(exp_i) || dump_data_o != regval(vi, cend, exp_i))
        bad_beats++;
      dump_ready_i = v.rdy[cyc % 4];
      if (dump_valid_o && dump_ready_i) exp_i++;
      set_regs(vi, cend + 1000 + cyc);
      @(negedge clk);
      start = 1'b0;
    end
    dump_ready_i = 1'b0;
    check($sformatf("v%0d beats_done", vi), exp_i, NREGS);
    check($sformatf("v%0d bad_beats", vi), bad_beats, 0);
    check($sformatf("v%0d done", vi), done_o, 1);
    check($sformatf("v%0d valid_in_done", vi), dump_valid_o, 0);
    repeat (2) @(negedge clk);
    check($sformatf("v%0d cycles_held", vi), cycles_o, v.exp_cycles);
    check($sformatf("v%0d busy_done", vi), busy_o, 0);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    vec_t rv;
    int   w;

    //         comp  at0  at1   en     rdy      per chk  cycles to
    vecs[0] = '{9,    200, 2000, 2'b00, 4'b1111, 0,  1,   10,    1'b0};
    vecs[1] = '{2100, 200, 2000, 2'b11, 4'b1111, 0,  1,   2101,  1'b0};
    vecs[2] = '{2100, 200, 2000, 2'b01, 4'b0110, 0,  1,   2101,  1'b0};
    vecs[3] = '{-1,   200, 2000, 2'b10, 4'b1111, 0,  1,   2500,  1'b1};
    vecs[4] = '{2499, 200, 2000, 2'b00, 4'b1001, 0,  1,   2500,  1'b0};
    vecs[5] = '{0,    0,   2000, 2'b01, 4'b1001, 0,  1,   1,     1'b0};
    vecs[6] = '{5,    4,   5,    2'b11, 4'b0101, 0,  1,   6,     1'b0};

    rstn = 1'b0;
    start = 1'b0;
    irq_en_i = '0;
    irq_at_i = '0;
    irq_period_i = '0;
    completed_i = 1'b0;
    regs_i = '0;
    dump_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    check("reset cpu_rstn", cpu_rstn_o, 0);
    check("reset busy", busy_o, 0);
    check("reset done", done_o, 0);
    check("reset valid", dump_valid_o, 0);
    check("reset cycles", cycles_o, 0);
    check("reset timeout", timeout_o, 0);
    check("reset irq", irq_o, 0);
    rstn = 1'b1;
    @(negedge clk);
    check("idle cpu_rstn", cpu_rstn_o, 0);

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // Reset in the middle of a dump, then a fresh run.
    irq_en_i = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    completed_i = 1'b1;
    set_regs(9, 0);
    @(negedge clk);
    completed_i = 1'b0;
    dump_ready_i = 1'b1;
    w = 0;
    while (!(dump_valid_o && dump_idx_o == 5'd7) && w < 40) begin
      @(negedge clk);
      w++;
    end
    check("abort reached idx7", dump_idx_o, 7);
    rstn = 1'b0;
    @(negedge clk);
    dump_ready_i = 1'b0;
    check("abort outputs zero",
          {cpu_rstn_o, irq_o, busy_o, cycles_o, timeout_o, dump_valid_o, dump_idx_o, dump_data_o, done_o},
          0);
    rstn = 1'b1;
    @(negedge clk);
    check("abort idle busy", busy_o, 0);
    rv = '{2, 200, 2000, 2'b00, 4'b1111, 0, 1, 3, 1'b0};
    run_vec(7, rv);

`ifdef RUN_CTRL_PERIODIC_IRQ_EN
    begin
      int exp_h[6];
      exp_h = '{11, 12, 61, 62, 111, 112};
      rv = '{115, 10, 3000, 2'b01, 4'b1111, 50, 0, 116, 1'b0};
      run_vec(8, rv);
      check("periodic hit count", hits0.size(), 6);
      for (int i = 0; i < 6; i++)
        check($sformatf("periodic hit%0d", i), (i < hits0.size()) ? hits0[i] : -1, exp_h[i]);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
